// File: rtl/systolic_feeder.sv
// Captures A/B on start, pulses the array clear, then streams skewed rows/columns
// into an output-stationary systolic array and flags done once every PE holds its final C.
module systolic_feeder #(
  parameter int DATA_WIDTH  = 8,
  parameter int A_ROWS      = 2,
  parameter int A_COLS      = 2,
  parameter int B_COLS      = 2,
  parameter int MAC_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] a_mat [0:A_ROWS-1][0:A_COLS-1],
  input  logic [DATA_WIDTH-1:0] b_mat [0:A_COLS-1][0:B_COLS-1],
  output logic                  busy,
  output logic                  done,
  output logic                  array_clr,
  output logic [DATA_WIDTH-1:0] a_out [0:A_ROWS-1],
  output logic [DATA_WIDTH-1:0] b_out [0:B_COLS-1]
);

  localparam int T_FEED = ((A_ROWS > B_COLS) ? A_ROWS : B_COLS) + A_COLS - 1;
  localparam int T_DONE = A_ROWS + A_COLS + B_COLS - 3 + MAC_LATENCY;
  localparam int TW     = $clog2(T_DONE + 1);

  typedef enum logic [2:0] {IDLE, CLEAR, FEED, DRAIN, DONE} state_t;

  state_t                state;
  logic [TW-1:0]         t;
  logic [TW-1:0]         t_nxt;
  logic [DATA_WIDTH-1:0] a_cap [0:A_ROWS-1][0:A_COLS-1];
  logic [DATA_WIDTH-1:0] b_cap [0:A_COLS-1][0:B_COLS-1];
  logic [DATA_WIDTH-1:0] a_nxt [0:A_ROWS-1];
  logic [DATA_WIDTH-1:0] b_nxt [0:B_COLS-1];

  // Outputs are registered, so the wavefront is computed for the cycle being entered.
  always_comb begin
    t_nxt = (state == FEED || state == DRAIN) ? t + TW'(1) : '0;
    for (int i = 0; i < A_ROWS; i++) begin
      a_nxt[i] = '0;
      for (int k = 0; k < A_COLS; k++) begin
        if (int'(t_nxt) - i == k) a_nxt[i] = a_cap[i][k];
      end
    end
    for (int j = 0; j < B_COLS; j++) begin
      b_nxt[j] = '0;
      for (int k = 0; k < A_COLS; k++) begin
        if (int'(t_nxt) - j == k) b_nxt[j] = b_cap[k][j];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      t         <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      array_clr <= 1'b0;
      a_out     <= '{default: '0};
      b_out     <= '{default: '0};
    end else begin
      case (state)
        IDLE, DONE: begin
          array_clr <= 1'b0;
          a_out     <= '{default: '0};
          b_out     <= '{default: '0};
          if (start) begin
            a_cap     <= a_mat;
            b_cap     <= b_mat;
            state     <= CLEAR;
            busy      <= 1'b1;
            done      <= 1'b0;
            array_clr <= 1'b1;
          end
        end
        CLEAR: begin
          state     <= FEED;
          t         <= '0;
          array_clr <= 1'b0;
          a_out     <= a_nxt;
          b_out     <= b_nxt;
        end
        FEED: begin
          t <= t_nxt;
          // With a single-row/column array and MAC_LATENCY=1 the drain phase is empty.
          if (int'(t_nxt) == T_DONE) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            a_out <= '{default: '0};
            b_out <= '{default: '0};
          end else if (int'(t_nxt) == T_FEED) begin
            state <= DRAIN;
            a_out <= '{default: '0};
            b_out <= '{default: '0};
          end else begin
            a_out <= a_nxt;
            b_out <= b_nxt;
          end
        end
        DRAIN: begin
          t <= t_nxt;
          if (int'(t_nxt) == T_DONE) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_systolic_feeder.sv
// Directed bench: two feeders (2x2x2 and 3x2x4), each driving a small behavioural systolic array.
module tb_systolic_feeder;

  logic       clk = 1'b0;
  logic       reset, start0, start1;
  logic [7:0] a0m [0:1][0:1];
  logic [7:0] b0m [0:1][0:1];
  logic [7:0] a0o [0:1];
  logic [7:0] b0o [0:1];
  logic       busy0, done0, clr0;
  logic [7:0] a1m [0:2][0:1];
  logic [7:0] b1m [0:1][0:3];
  logic [7:0] a1o [0:2];
  logic [7:0] b1o [0:3];
  logic       busy1, done1, clr1;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0]  ea [0:1][0:5];
  logic [7:0]  eb [0:1][0:5];
  logic [15:0] ec [0:1][0:1];

  always #5 clk = ~clk;

  systolic_feeder #(.DATA_WIDTH(8), .A_ROWS(2), .A_COLS(2), .B_COLS(2), .MAC_LATENCY(2)) d0 (
    .clk(clk), .reset(reset), .start(start0), .a_mat(a0m), .b_mat(b0m),
    .busy(busy0), .done(done0), .array_clr(clr0), .a_out(a0o), .b_out(b0o));

  systolic_feeder #(.DATA_WIDTH(8), .A_ROWS(3), .A_COLS(2), .B_COLS(4), .MAC_LATENCY(2)) d1 (
    .clk(clk), .reset(reset), .start(start1), .a_mat(a1m), .b_mat(b1m),
    .busy(busy1), .done(done1), .array_clr(clr1), .a_out(a1o), .b_out(b1o));

  // Array models: row i stream reaches PE(i,j) j cycles late, column j stream reaches it i cycles late.
  logic [7:0]  ah0 [0:1][0:1];
  logic [7:0]  bh0 [0:1][0:1];
  logic [15:0] c0  [0:1][0:1];
  always @(posedge clk) begin
    if (clr0) begin
      for (int i = 0; i < 2; i++)
        for (int d = 0; d < 2; d++) begin
          ah0[i][d] = '0; bh0[i][d] = '0; c0[i][d] = '0;
        end
    end else begin
      for (int i = 0; i < 2; i++) begin
        for (int d = 1; d > 0; d--) begin
          ah0[i][d] = ah0[i][d-1]; bh0[i][d] = bh0[i][d-1];
        end
        ah0[i][0] = a0o[i]; bh0[i][0] = b0o[i];
      end
      for (int i = 0; i < 2; i++)
        for (int j = 0; j < 2; j++)
          c0[i][j] = c0[i][j] + 16'(ah0[i][j]) * 16'(bh0[j][i]);
    end
  end

  logic [7:0]  ah1 [0:2][0:3];
  logic [7:0]  bh1 [0:3][0:2];
  logic [15:0] c1  [0:2][0:3];
  always @(posedge clk) begin
    if (clr1) begin
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 4; j++) begin
          ah1[i][j] = '0; bh1[j][i] = '0; c1[i][j] = '0;
        end
    end else begin
      for (int i = 0; i < 3; i++) begin
        for (int d = 3; d > 0; d--) ah1[i][d] = ah1[i][d-1];
        ah1[i][0] = a1o[i];
      end
      for (int j = 0; j < 4; j++) begin
        for (int d = 2; d > 0; d--) bh1[j][d] = bh1[j][d-1];
        bh1[j][0] = b1o[j];
      end
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 4; j++)
          c1[i][j] = c1[i][j] + 16'(ah1[i][j]) * 16'(bh1[j][i]);
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle0(input string tag);
    chk(tag, {busy0, done0, clr0, a0o[0], a0o[1], b0o[0], b0o[1]}, 64'd0);
  endtask

  task automatic chk_idle1(input string tag);
    chk(tag, {busy1, done1, clr1, a1o[0], a1o[1], a1o[2], b1o[0], b1o[1], b1o[2], b1o[3]}, 64'd0);
  endtask

  // Entered just after the edge that moved d0 into CLEAR; walks t=0..5 against ea/eb/ec.
  task automatic run0(input string tag, input bit hold, input bit inject);
    chk({tag, "_clear"}, {busy0, done0, clr0}, 3'b101);
    start0 = hold;
    for (int t = 0; t <= 5; t++) begin
      tick();
      chk($sformatf("%s_a_t%0d", tag, t), {a0o[0], a0o[1]}, {ea[0][t], ea[1][t]});
      chk($sformatf("%s_b_t%0d", tag, t), {b0o[0], b0o[1]}, {eb[0][t], eb[1][t]});
      chk($sformatf("%s_ctl_t%0d", tag, t), {busy0, done0, clr0}, (t == 5) ? 3'b010 : 3'b100);
      start0 = (hold && t < 5) || (inject && t == 1);
      if (inject && t == 1) a0m = '{'{8'd90, 8'd91}, '{8'd92, 8'd93}};
    end
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++)
        chk($sformatf("%s_c%0d%0d", tag, i, j), c0[i][j], ec[i][j]);
  endtask

  logic [7:0]  ea1 [0:2][0:8];
  logic [7:0]  eb1 [0:3][0:8];
  logic [15:0] ec1 [0:2][0:3];

  initial begin
    reset = 1'b1; start0 = 1'b0; start1 = 1'b0;
    a0m = '{default: '0}; b0m = '{default: '0};
    a1m = '{default: '0}; b1m = '{default: '0};
    tick(); tick();
    chk_idle0("reset0");
    chk_idle1("reset1");
    reset = 1'b0;
    for (int c = 0; c < 20; c++) begin
      tick();
      chk_idle0($sformatf("idle0_c%0d", c));
      chk_idle1($sformatf("idle1_c%0d", c));
    end

    // Run 1 with a start pulse injected at FEED t=1 carrying different A.
    a0m = '{'{8'd1, 8'd2}, '{8'd3, 8'd4}};
    b0m = '{'{8'd5, 8'd6}, '{8'd7, 8'd8}};
    ea = '{'{8'd1, 8'd2, 8'd0, 8'd0, 8'd0, 8'd0}, '{8'd0, 8'd3, 8'd4, 8'd0, 8'd0, 8'd0}};
    eb = '{'{8'd5, 8'd7, 8'd0, 8'd0, 8'd0, 8'd0}, '{8'd0, 8'd6, 8'd8, 8'd0, 8'd0, 8'd0}};
    ec = '{'{16'd19, 16'd22}, '{16'd43, 16'd50}};
    start0 = 1'b1;
    tick();
    run0("run1", 1'b0, 1'b1);
    tick();
    chk("done_hold", {busy0, done0, clr0, a0o[0], a0o[1], b0o[0], b0o[1]}, {3'b010, 32'd0});

    // Back-to-back from DONE with start held high through the run.
    a0m = '{'{8'd1, 8'd0}, '{8'd0, 8'd1}};
    b0m = '{'{8'd9, 8'd8}, '{8'd7, 8'd6}};
    ea = '{'{8'd1, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0}, '{8'd0, 8'd0, 8'd1, 8'd0, 8'd0, 8'd0}};
    eb = '{'{8'd9, 8'd7, 8'd0, 8'd0, 8'd0, 8'd0}, '{8'd0, 8'd8, 8'd6, 8'd0, 8'd0, 8'd0}};
    ec = '{'{16'd9, 16'd8}, '{16'd7, 16'd6}};
    start0 = 1'b1;
    tick();
    run0("b2b", 1'b1, 1'b0);

    // Reset at FEED t=2, then a clean rerun.
    a0m = '{'{8'd1, 8'd2}, '{8'd3, 8'd4}};
    b0m = '{'{8'd5, 8'd6}, '{8'd7, 8'd8}};
    ea = '{'{8'd1, 8'd2, 8'd0, 8'd0, 8'd0, 8'd0}, '{8'd0, 8'd3, 8'd4, 8'd0, 8'd0, 8'd0}};
    eb = '{'{8'd5, 8'd7, 8'd0, 8'd0, 8'd0, 8'd0}, '{8'd0, 8'd6, 8'd8, 8'd0, 8'd0, 8'd0}};
    ec = '{'{16'd19, 16'd22}, '{16'd43, 16'd50}};
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    tick(); tick(); tick();
    chk("mid_t2_a", {a0o[0], a0o[1], busy0}, {8'd0, 8'd4, 1'b1});
    reset = 1'b1;
    tick();
    chk_idle0("mid_reset");
    reset = 1'b0;
    tick();
    chk_idle0("post_reset");
    start0 = 1'b1;
    tick();
    run0("rerun", 1'b0, 1'b0);

    // Non-square 3x2x4: A[i][k]=i+k+1, B[k][j]=j+1.
    a1m = '{'{8'd1, 8'd2}, '{8'd2, 8'd3}, '{8'd3, 8'd4}};
    b1m = '{'{8'd1, 8'd2, 8'd3, 8'd4}, '{8'd1, 8'd2, 8'd3, 8'd4}};
    ea1 = '{'{8'd1, 8'd2, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0},
            '{8'd0, 8'd2, 8'd3, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0},
            '{8'd0, 8'd0, 8'd3, 8'd4, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0}};
    eb1 = '{'{8'd1, 8'd1, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0},
            '{8'd0, 8'd2, 8'd2, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0},
            '{8'd0, 8'd0, 8'd3, 8'd3, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0},
            '{8'd0, 8'd0, 8'd0, 8'd4, 8'd4, 8'd0, 8'd0, 8'd0, 8'd0}};
    ec1 = '{'{16'd3, 16'd6, 16'd9, 16'd12},
            '{16'd5, 16'd10, 16'd15, 16'd20},
            '{16'd7, 16'd14, 16'd21, 16'd28}};
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    chk("ns_clear", {busy1, done1, clr1}, 3'b101);
    for (int t = 0; t <= 8; t++) begin
      tick();
      chk($sformatf("ns_a_t%0d", t), {a1o[0], a1o[1], a1o[2]}, {ea1[0][t], ea1[1][t], ea1[2][t]});
      chk($sformatf("ns_b_t%0d", t), {b1o[0], b1o[1], b1o[2], b1o[3]},
          {eb1[0][t], eb1[1][t], eb1[2][t], eb1[3][t]});
      chk($sformatf("ns_ctl_t%0d", t), {busy1, done1, clr1}, (t == 8) ? 3'b010 : 3'b100);
    end
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 4; j++)
        chk($sformatf("ns_c%0d%0d", i, j), c1[i][j], ec1[i][j]);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
